// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with per-frame digit snapshot.
// Optional leading-zero suppression is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_BITS = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_DIGITS*DIGIT_BITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]            dp_in,
    input  logic                             blank,
    output logic [6:0]                       seg_out,
    output logic                             dp_out,
    output logic [NUM_DIGITS-1:0]            an_out,
    output logic                             frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]                div_p0;
    logic [IDX_W-1:0]                idx_p0;
    logic [NUM_DIGITS*DIGIT_BITS-1:0] snap_p0;
    logic [NUM_DIGITS-1:0]           dp_snap_p0;

    logic [NUM_DIGITS*DIGIT_BITS-1:0] sel_digits;
    logic [NUM_DIGITS-1:0]           sel_dp;
    logic [DIGIT_BITS-1:0]           cur_digit;
    logic                            cur_dp;
    logic [NUM_DIGITS-1:0]           an_onehot;
    logic                            lz_blank;
    logic                            zero_run;

    logic [6:0]                      seg_p1;
    logic                            dp_p1;
    logic [NUM_DIGITS-1:0]           an_p1;

    function automatic logic [6:0] decode_seg(input logic [DIGIT_BITS-1:0] d);
        logic [6:0] s;
        case (int'(d))
            0:       s = 7'h3F;
            1:       s = 7'h06;
            2:       s = 7'h5B;
            3:       s = 7'h4F;
            4:       s = 7'h66;
            5:       s = 7'h6D;
            6:       s = 7'h7D;
            7:       s = 7'h07;
            8:       s = 7'h7F;
            9:       s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign frame_start = (div_p0 == '0) && (idx_p0 == '0);

    // Stage p0: pick live inputs on the frame's first cycle, snapshot otherwise
    always_comb begin
        sel_digits = frame_start ? digits_in : snap_p0;
        sel_dp     = frame_start ? dp_in     : dp_snap_p0;
        cur_digit  = '0;
        cur_dp     = 1'b0;
        an_onehot  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_p0 == IDX_W'(k)) begin
                cur_digit    = sel_digits[k*DIGIT_BITS +: DIGIT_BITS];
                cur_dp       = sel_dp[k];
                an_onehot[k] = 1'b1;
            end
        end
    end

    always_comb begin
        lz_blank = 1'b0;
        zero_run = 1'b1;
`ifdef SEG7_LZ_BLANK_EN
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (sel_digits[k*DIGIT_BITS +: DIGIT_BITS] == '0) && !sel_dp[k];
            if (idx_p0 == IDX_W'(k))
                lz_blank = zero_run;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_p0     <= '0;
            idx_p0     <= '0;
            snap_p0    <= '0;
            dp_snap_p0 <= '0;
        end else begin
            if (div_p0 == DIV_LAST) begin
                div_p0 <= '0;
                idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
            end else begin
                div_p0 <= div_p0 + 1'b1;
            end
            if (frame_start) begin
                snap_p0    <= digits_in;
                dp_snap_p0 <= dp_in;
            end
        end
    end

    // Stage p1: registered display drive, internally active-high
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_p1 <= '0;
            dp_p1  <= 1'b0;
            an_p1  <= '0;
        end else begin
            an_p1  <= blank ? '0 : an_onehot;
            seg_p1 <= (blank || lz_blank) ? 7'h00 : decode_seg(cur_digit);
            dp_p1  <= !(blank || lz_blank) && cur_dp;
        end
    end

    assign seg_out = (ACTIVE_LOW != 0) ? ~seg_p1 : seg_p1;
    assign dp_out  = (ACTIVE_LOW != 0) ? ~dp_p1  : dp_p1;
    assign an_out  = (ACTIVE_LOW != 0) ? ~an_p1  : an_p1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (4 digits, SCAN_DIV=4, active-low).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_start;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    seg7_scan_driver #(
        .NUM_DIGITS(4),
        .DIGIT_BITS(4),
        .SCAN_DIV  (4),
        .ACTIVE_LOW(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank      (blank),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_out     (an_out),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // cyc = number of active edges since reset release; sample 1ns after the edge
    task automatic goto_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        digits_in = 16'h1234;
        dp_in     = 4'b0000;
        blank     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (an_out !== 4'hF || seg_out !== 7'h7F || dp_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: an=%h seg=%h dp=%b required an=F seg=7F dp=1", an_out, seg_out, dp_out);
        end
        rst = 1'b0;
        cyc = 0;
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL first_frame_start: got %b required 1", frame_start);
        end
    endtask

    task automatic test_scan;
        goto_cyc(1);
        checks++;
        if (an_out !== 4'hE || seg_out !== 7'h19) begin
            errors++;
            $display("FAIL slot0_4: an=%h seg=%h required an=E seg=19", an_out, seg_out);
        end
        goto_cyc(5);
        checks++;
        if (an_out !== 4'hD || seg_out !== 7'h30) begin
            errors++;
            $display("FAIL slot1_3: an=%h seg=%h required an=D seg=30", an_out, seg_out);
        end
        goto_cyc(9);
        checks++;
        if (an_out !== 4'hB || seg_out !== 7'h24) begin
            errors++;
            $display("FAIL slot2_2: an=%h seg=%h required an=B seg=24", an_out, seg_out);
        end
        goto_cyc(13);
        checks++;
        if (an_out !== 4'h7 || seg_out !== 7'h79) begin
            errors++;
            $display("FAIL slot3_1: an=%h seg=%h required an=7 seg=79", an_out, seg_out);
        end
        goto_cyc(15);
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL frame_start_low: got %b required 0", frame_start);
        end
        goto_cyc(16);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL frame_period_16: got %b required 1", frame_start);
        end
    endtask

    task automatic test_midframe;
        goto_cyc(25);
        digits_in = 16'h5678;
        goto_cyc(27);
        checks++;
        if (an_out !== 4'hB || seg_out !== 7'h24) begin
            errors++;
            $display("FAIL torn_slot2: an=%h seg=%h required an=B seg=24", an_out, seg_out);
        end
        goto_cyc(29);
        checks++;
        if (an_out !== 4'h7 || seg_out !== 7'h79) begin
            errors++;
            $display("FAIL torn_slot3: an=%h seg=%h required an=7 seg=79", an_out, seg_out);
        end
        goto_cyc(33);
        checks++;
        if (an_out !== 4'hE || seg_out !== 7'h00) begin
            errors++;
            $display("FAIL new_slot0_8: an=%h seg=%h required an=E seg=00", an_out, seg_out);
        end
        goto_cyc(37);
        checks++;
        if (seg_out !== 7'h78) begin
            errors++;
            $display("FAIL new_slot1_7: seg=%h required 78", seg_out);
        end
        goto_cyc(41);
        checks++;
        if (seg_out !== 7'h02) begin
            errors++;
            $display("FAIL new_slot2_6: seg=%h required 02", seg_out);
        end
        goto_cyc(45);
        checks++;
        if (seg_out !== 7'h12) begin
            errors++;
            $display("FAIL new_slot3_5: seg=%h required 12", seg_out);
        end
    endtask

    task automatic test_dash_dp;
        digits_in = 16'hF10A;
        dp_in     = 4'b0010;
        goto_cyc(49);
        checks++;
        if (an_out !== 4'hE || seg_out !== 7'h3F || dp_out !== 1'b1) begin
            errors++;
            $display("FAIL dash_slot0: an=%h seg=%h dp=%b required an=E seg=3F dp=1", an_out, seg_out, dp_out);
        end
        goto_cyc(53);
        checks++;
        if (an_out !== 4'hD || seg_out !== 7'h40 || dp_out !== 1'b0) begin
            errors++;
            $display("FAIL dp_slot1: an=%h seg=%h dp=%b required an=D seg=40 dp=0", an_out, seg_out, dp_out);
        end
        goto_cyc(57);
        checks++;
        if (an_out !== 4'hB || dp_out !== 1'b1) begin
            errors++;
            $display("FAIL dp_slot2_off: an=%h dp=%b required an=B dp=1", an_out, dp_out);
        end
        goto_cyc(61);
        checks++;
        if (an_out !== 4'h7 || seg_out !== 7'h3F) begin
            errors++;
            $display("FAIL dash_slot3: an=%h seg=%h required an=7 seg=3F", an_out, seg_out);
        end
    endtask

    task automatic test_blank;
        goto_cyc(66);
        blank = 1'b1;
        goto_cyc(67);
        checks++;
        if (an_out !== 4'hF || seg_out !== 7'h7F || dp_out !== 1'b1) begin
            errors++;
            $display("FAIL blank_on: an=%h seg=%h dp=%b required an=F seg=7F dp=1", an_out, seg_out, dp_out);
        end
        goto_cyc(72);
        checks++;
        if (an_out !== 4'hF) begin
            errors++;
            $display("FAIL blank_hold: an=%h required F", an_out);
        end
        blank = 1'b0;
        goto_cyc(73);
        checks++;
        if (an_out !== 4'hB || seg_out !== 7'h79) begin
            errors++;
            $display("FAIL blank_resume_phase: an=%h seg=%h required an=B seg=79", an_out, seg_out);
        end
        goto_cyc(80);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL blank_frame_phase: got %b required 1", frame_start);
        end
    endtask

    task automatic test_reset_midslot;
        goto_cyc(82);
        rst = 1'b1;
        goto_cyc(83);
        checks++;
        if (an_out !== 4'hF || seg_out !== 7'h7F || dp_out !== 1'b1 || frame_start !== 1'b1) begin
            errors++;
            $display("FAIL reset_midslot: an=%h seg=%h dp=%b fs=%b required F 7F 1 1", an_out, seg_out, dp_out, frame_start);
        end
        rst = 1'b0;
        cyc = 0;
        goto_cyc(1);
        checks++;
        if (an_out !== 4'hE || seg_out !== 7'h3F) begin
            errors++;
            $display("FAIL reset_restart: an=%h seg=%h required an=E seg=3F", an_out, seg_out);
        end
    endtask

    task automatic test_zero_digits;
        logic [6:0] exp_hi;
`ifdef SEG7_LZ_BLANK_EN
        exp_hi = 7'h7F;
`else
        exp_hi = 7'h40;
`endif
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        goto_cyc(17);
        checks++;
        if (an_out !== 4'hE || seg_out !== 7'h40) begin
            errors++;
            $display("FAIL zero_digit0: an=%h seg=%h required an=E seg=40", an_out, seg_out);
        end
        goto_cyc(21);
        checks++;
        if (an_out !== 4'hD || seg_out !== exp_hi) begin
            errors++;
            $display("FAIL zero_digit1: an=%h seg=%h required an=D seg=%h", an_out, seg_out, exp_hi);
        end
        goto_cyc(29);
        checks++;
        if (an_out !== 4'h7 || seg_out !== exp_hi) begin
            errors++;
            $display("FAIL zero_digit3: an=%h seg=%h required an=7 seg=%h", an_out, seg_out, exp_hi);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe();
        test_dash_dp();
        test_blank();
        test_reset_midslot();
        test_zero_digits();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
